sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-ported, synchronous-read SRAM between the
// instruction-fetch port and the data load/store port.
//
// One grant per cycle, decided combinationally. The response comes back
// exactly one cycle later, and a new grant may be issued in that same cycle.
//
// Build option ARB_RR_EN:
//   defined   - round-robin between the two ports.
//   undefined - data port has priority. The instruction port is forced
//               through after STARVE_LIMIT consecutive data grants.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | no response due this cycle
// RESP_INST | fetch granted last cycle, inst_data_ok now
// RESP_DATA | data access granted last cycle, data_data_ok now
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RESP_INST = 2'b10,
    RESP_DATA = 2'b11
  } resp_state_t;

  resp_state_t state_q, state_d;
  logic        resp_valid;
  logic        resp_src;
  logic        rst_hold_q;
  logic        arb_en;
  logic        grant_inst;
  logic        grant_data;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  // No grants while reset is high or in the first cycle after it falls.
  assign arb_en = !reset && !rst_hold_q;

  // Remember that reset was high last cycle.
  always_ff @(posedge clk) begin
    rst_hold_q <= reset;
  end

`ifdef ARB_RR_EN
  logic last_grant_q;  // 0 = inst granted most recently, 1 = data

  // On contention, favour the port that was not granted last. A port that
  // requests alone always wins.
  always_comb begin
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    starve_cnt_d = '0;
    if (arb_en) begin
      if (inst_req && data_req) begin
        grant_data = !last_grant_q;
        grant_inst = last_grant_q;
      end else begin
        grant_data = data_req;
        grant_inst = inst_req;
      end
    end
  end

  // Track which port was granted most recently. Reset makes it look as if
  // inst went last, so data wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (reset)           last_grant_q <= 1'b0;
    else if (grant_inst) last_grant_q <= 1'b0;
    else if (grant_data) last_grant_q <= 1'b1;
  end
`else
  localparam logic [3:0] LIMIT_CNT = 4'(STARVE_LIMIT);
  logic starve_force;

  assign starve_force = (starve_cnt_q == LIMIT_CNT);

  // Data wins unless a waiting fetch has already lost LIMIT_CNT times in a
  // row. The counter only runs while a fetch is actually waiting.
  always_comb begin
    grant_data   = arb_en && data_req && !(inst_req && starve_force);
    grant_inst   = arb_en && inst_req && !grant_data;
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || grant_inst) starve_cnt_d = '0;
    else if (grant_data)         starve_cnt_d = starve_cnt_q + 4'd1;
  end
`endif

  // Starvation counter register. In the round-robin build it stays at 0.
  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  // Response-tracking state register. Reset drops any response in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state is fixed by this cycle's grant, whatever the current state.
  always_comb begin
    state_d = IDLE;
    if (grant_inst)      state_d = RESP_INST;
    else if (grant_data) state_d = RESP_DATA;
  end

  assign resp_valid = (state_q != IDLE);
  assign resp_src   = (state_q == RESP_DATA);

  // Drive the SRAM from the granted port, and route read data back to the
  // port that owns the response.
  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    inst_data_ok = !reset && resp_valid && !resp_src;
    data_data_ok = !reset && resp_valid && resp_src;
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
    sram_en      = grant_inst || grant_data;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (grant_inst) begin
      sram_addr = inst_addr;
    end else if (grant_data) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      if (data_wr) sram_we = data_wstrb;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: runs directed scenarios first, then randomized traffic
// with occasional resets. A behavioural SRAM is attached to the DUT, and a
// reference model predicts grants, responses and read data.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;

  bit [31:0] sram_mem [1024];
  bit [31:0] ref_mem  [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural synchronous-read SRAM: the read returns the old contents,
  // and byte writes land at the clock edge.
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= sram_mem[sram_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference model state
  bit          prev_rst = 1'b1;
  int          consec_d = 0;       // data wins in a row while a fetch waited
  bit          last_inst = 1'b1;   // inst counts as most recent at reset
  bit          pend_v = 1'b0, pend_d = 1'b0, pend_load = 1'b0;
  logic [31:0] pend_rdata = '0;
  bit          m_en, m_gi, m_gd;
  int          m_idx;
  logic [31:0] m_addr;

  // Model and checker, evaluated mid-cycle against the inputs driven this cycle.
  always @(negedge clk) begin
    m_en = !reset && !prev_rst;
    if (reset) pend_v = 1'b0;
    chk("data_ok", {30'd0, inst_data_ok, data_data_ok}, {30'd0, pend_v && !pend_d, pend_v && pend_d});
    if (pend_v && pend_load)
      chk(pend_d ? "data_rdata" : "inst_rdata", pend_d ? data_rdata : inst_rdata, pend_rdata);
    if (reset) chk("rdata_rst", inst_rdata | data_rdata, 32'h0);

    m_gi = 1'b0;
    m_gd = 1'b0;
    if (m_en) begin
      if (inst_req && data_req) begin
`ifdef ARB_RR_EN
        m_gd = last_inst;
`else
        m_gd = (consec_d < int'(LIMIT));
`endif
        m_gi = !m_gd;
      end else begin
        m_gi = inst_req;
        m_gd = data_req;
      end
    end
    chk("grant", {29'd0, inst_addr_ok, data_addr_ok, sram_en}, {29'd0, m_gi, m_gd, m_gi | m_gd});
    chk("sram_we", {28'd0, sram_we}, {28'd0, (m_gd && data_wr) ? data_wstrb : 4'b0000});
    m_addr = m_gi ? inst_addr : (m_gd ? data_addr : 32'h0);
    chk("sram_addr", sram_addr, m_addr);
    if (!m_gi) chk("sram_wdata", sram_wdata, m_gd ? data_wdata : 32'h0);

    if (reset) begin
      consec_d  = 0;
      last_inst = 1'b1;
    end else if (m_en) begin
      if (m_gd && inst_req) consec_d++;
      else                  consec_d = 0;
      if (m_gi)      last_inst = 1'b1;
      else if (m_gd) last_inst = 1'b0;
    end

    pend_v    = m_gi | m_gd;
    pend_d    = m_gd;
    pend_load = m_gi || (m_gd && !data_wr);
    m_idx     = int'(m_addr[11:2]);
    pend_rdata = ref_mem[m_idx];
    if (m_gd && data_wr)
      for (int b = 0; b < 4; b++)
        if (data_wstrb[b]) ref_mem[m_idx][8*b +: 8] = data_wdata[8*b +: 8];
    prev_rst = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
  endtask

  // Ends at the start of the first cycle in which grants are possible.
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  logic        ia, da;
  logic [1:0]  exp_g;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 32'h9e37_79b9 * i;
      ref_mem[i]  = 32'h9e37_79b9 * i;
    end
    sram_mem[0]     = 32'h02800c0c;  ref_mem[0]     = 32'h02800c0c;
    sram_mem[12'h40] = 32'h11223344; ref_mem[12'h40] = 32'h11223344;
    sram_mem[12'h41] = 32'h55667788; ref_mem[12'h41] = 32'h55667788;

    idle_in();
    do_reset();

    // single fetch
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    #2 chk("fetch_aok", {25'd0, inst_addr_ok, sram_en, sram_we, data_addr_ok}, {25'd0, 7'b1100000});
    cyc();
    inst_req = 1'b0;
    #2 chk("fetch_dok", {31'd0, inst_data_ok}, 32'd1);
    chk("fetch_rdata", inst_rdata, 32'h02800c0c);
    chk("fetch_data_quiet", {30'd0, data_addr_ok, data_data_ok} | data_rdata, 32'h0);

    // store then load to the same word
    cyc();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h100; data_wdata = 32'hAABBCCDD;
    #2 chk("st_aok", {27'd0, data_addr_ok, sram_we}, {27'd0, 1'b1, 4'b0011});
    cyc();
    data_wr = 1'b0; data_wstrb = 4'b0000;
    #2 chk("st_dok", {30'd0, data_data_ok, data_addr_ok}, 32'd3);
    cyc();
    data_req = 1'b0;
    #2 chk("ld_dok", {31'd0, data_data_ok}, 32'd1);
    chk("ld_rdata", data_rdata, 32'h1122CCDD);

    // zero-strobe store leaves the word untouched
    cyc();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0000;
    data_addr = 32'h104; data_wdata = 32'hFFFFFFFF;
    #2 chk("zs_aok", {26'd0, data_addr_ok, sram_en, sram_we}, {26'd0, 6'b110000});
    cyc();
    data_wr = 1'b0;
    #2 chk("zs_dok", {31'd0, data_data_ok}, 32'd1);
    cyc();
    data_req = 1'b0;
    #2 chk("zs_rdata", data_rdata, 32'h55667788);

    // reset while a fetch response is due
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    #2 chk("rmt_aok", {31'd0, inst_addr_ok}, 32'd1);
    cyc();
    reset = 1'b1;
    #2 chk("rmt_in_rst", {29'd0, inst_data_ok, inst_addr_ok, sram_en}, 32'd0);
    cyc();
    reset = 1'b0;
    #2 chk("rmt_after", {27'd0, inst_data_ok, inst_addr_ok, sram_en, data_data_ok, data_addr_ok}, 32'd0);
    cyc();
    #2 chk("rmt_live", {31'd0, inst_addr_ok}, 32'd1);
    cyc();
    idle_in();

    // sustained contention from a fresh reset
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h10c;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h108;
    for (int i = 0; i < 12; i++) begin
`ifdef ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = (i % (LIMIT + 1) == LIMIT) ? 2'b10 : 2'b01;
`endif
      #2 chk("contend", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, exp_g});
      cyc();
    end
    idle_in();

    // randomized traffic; masters hold a request until it is accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ia = inst_addr_ok;
      da = data_addr_ok;
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 99) == 0);
      if (!inst_req || ia) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = ($urandom_range(0, 7) == 0) ? 32'h1c000000
                                                : 32'h100 + ($urandom_range(0, 15) << 2);
      end
      if (!data_req || da) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = $urandom_range(0, 1) == 1;
        data_wstrb = 4'($urandom_range(0, 15));
        data_addr  = 32'h100 + ($urandom_range(0, 15) << 2);
        data_wdata = $urandom;
      end
    end

    reset = 1'b0;
    idle_in();
    cyc();
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
